// File: rtl/rab_port_lookup_ctrl_if.sv
// Request-channel bundle between the AXI address channels and one RAB port
// lookup controller: N_CH request lanes in, accept/drop and translation out.
interface rab_port_lookup_ctrl_if #(
  parameter int N_CH       = 2,
  parameter int ADDR_WIDTH = 32,
  parameter int ID_WIDTH   = 8,
  parameter int USER_WIDTH = 6
);
  logic [N_CH-1:0]            req_valid;
  logic [N_CH*ADDR_WIDTH-1:0] req_addr;
  logic [N_CH*ID_WIDTH-1:0]   req_id;
  logic [N_CH*8-1:0]          req_len;
  logic [N_CH*3-1:0]          req_size;
  logic [N_CH-1:0]            req_type;
  logic [N_CH*USER_WIDTH-1:0] req_ctrl;
  logic [N_CH-1:0]            req_sent;
  logic [N_CH-1:0]            accept;
  logic [N_CH-1:0]            drop;
  logic [ADDR_WIDTH-1:0]      out_addr;

  modport master (
    output req_valid, req_addr, req_id, req_len, req_size, req_type, req_ctrl, req_sent,
    input  accept, drop, out_addr
  );

  modport slave (
    input  req_valid, req_addr, req_id, req_len, req_size, req_type, req_ctrl, req_sent,
    output accept, drop, out_addr
  );
endinterface

// File: rtl/rab_port_lookup_ctrl.sv
// Per-port RAB lookup controller: round-robin arbitration over N_CH channels,
// a registered slice lookup, and accept/miss/prot/multi classification.
module rab_port_lookup_ctrl #(
  parameter int N_CH           = 2,
  parameter int ADDR_WIDTH     = 32,
  parameter int ID_WIDTH       = 8,
  parameter int USER_WIDTH     = 6,
  parameter int AXI_DATA_WIDTH = 64,
  parameter int RAB_ENTRIES    = 16,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                           s_axi_aclk,
  input  logic                           s_axi_aresetn,
  rab_port_lookup_ctrl_if.slave          req_if,
  output logic                           lk_valid,
  output logic [ADDR_WIDTH-1:0]          lk_addr_min,
  output logic [ADDR_WIDTH-1:0]          lk_addr_max,
  output logic                           lk_rw,
  input  logic [RAB_ENTRIES-1:0]         lk_hit,
  input  logic [RAB_ENTRIES-1:0]         lk_prot,
  input  logic [ADDR_WIDTH-1:0]          lk_out_addr,
  output logic                           int_miss,
  output logic                           int_prot,
  output logic                           int_multi,
  output logic [ADDR_WIDTH-1:0]          miss_addr,
  output logic [$clog2(N_CH)+ID_WIDTH-1:0] miss_id,
  input  logic                           cnt_clr,
  output logic [CNT_WIDTH-1:0]           miss_count
);
  localparam int AW   = $clog2(AXI_DATA_WIDTH / 8);
  localparam int CH_W = $clog2(N_CH);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] LOOKUP    = 2'd1;
  localparam logic [1:0] RESPOND   = 2'd2;
  localparam logic [1:0] WAIT_SENT = 2'd3;

  logic [1:0]               state_q, state_d;
  logic [CH_W-1:0]          last_q, last_d;
  logic [CH_W-1:0]          gnt_q, gnt_d;
  logic [ADDR_WIDTH-1:0]    min_q, min_d;
  logic [ADDR_WIDTH-1:0]    max_q, max_d;
  logic                     rw_q, rw_d;
  logic [ID_WIDTH-1:0]      id_q, id_d;
  logic [ADDR_WIDTH-1:0]    out_addr_q, out_addr_d;
  logic [N_CH-1:0]          accept_q, accept_d;
  logic [N_CH-1:0]          drop_q, drop_d;
  logic                     int_miss_q, int_miss_d;
  logic                     int_prot_q, int_prot_d;
  logic                     int_multi_q, int_multi_d;
  logic [ADDR_WIDTH-1:0]    miss_addr_q, miss_addr_d;
  logic [CH_W+ID_WIDTH-1:0] miss_id_q, miss_id_d;
  logic [CNT_WIDTH-1:0]     miss_count_q, miss_count_d;

  logic                     grant_vld;
  logic [CH_W-1:0]          grant_ch;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [ID_WIDTH-1:0]      sel_id;
  logic [7:0]               sel_len;
  logic [2:0]               sel_size;
  logic                     sel_type;
  logic [USER_WIDTH-1:0]    sel_ctrl;
  logic                     sel_bypass;
  int                       align_bits;
  logic [ADDR_WIDTH-1:0]    align_mask;
  logic [ADDR_WIDTH-1:0]    sel_max;
  logic                     hit_any;
  logic                     hit_multi;
  logic                     prot_any;

  // Search starts one past the last winner so every channel gets a turn.
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int i = 1; i <= N_CH; i++) begin
      if (!grant_vld && req_if.req_valid[(int'(last_q) + i) % N_CH]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'((int'(last_q) + i) % N_CH);
      end
    end
  end

  always_comb begin
    sel_addr   = req_if.req_addr[int'(grant_ch)*ADDR_WIDTH +: ADDR_WIDTH];
    sel_id     = req_if.req_id[int'(grant_ch)*ID_WIDTH +: ID_WIDTH];
    sel_len    = req_if.req_len[int'(grant_ch)*8 +: 8];
    sel_size   = req_if.req_size[int'(grant_ch)*3 +: 3];
    sel_type   = req_if.req_type[grant_ch];
    sel_ctrl   = req_if.req_ctrl[int'(grant_ch)*USER_WIDTH +: USER_WIDTH];
    sel_bypass = &sel_ctrl;
  end

  // Burst end is computed from the bus-aligned start; overflow wraps.
  always_comb begin
    align_bits = (int'(sel_size) < AW) ? int'(sel_size) : AW;
    align_mask = ~((ADDR_WIDTH'(1) << align_bits) - ADDR_WIDTH'(1));
    sel_max    = (sel_addr & align_mask)
               + ((ADDR_WIDTH'(sel_len) + ADDR_WIDTH'(1)) << sel_size)
               - ADDR_WIDTH'(1);
  end

  always_comb begin
    hit_any   = 1'b0;
    hit_multi = 1'b0;
    for (int i = 0; i < RAB_ENTRIES; i++) begin
      if (lk_hit[i]) begin
        hit_multi = hit_multi | hit_any;
        hit_any   = 1'b1;
      end
    end
    prot_any = |lk_prot;
  end

  // Pulse flops are loaded on the way into RESPOND so they fire exactly there.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    gnt_d       = gnt_q;
    min_d       = min_q;
    max_d       = max_q;
    rw_d        = rw_q;
    id_d        = id_q;
    out_addr_d  = out_addr_q;
    accept_d    = '0;
    drop_d      = '0;
    int_miss_d  = 1'b0;
    int_prot_d  = 1'b0;
    int_multi_d = 1'b0;
    miss_addr_d = miss_addr_q;
    miss_id_d   = miss_id_q;
    case (state_q)
      IDLE: begin
        if (grant_vld) begin
          gnt_d  = grant_ch;
          last_d = grant_ch;
          min_d  = sel_addr;
          max_d  = sel_max;
          rw_d   = sel_type;
          id_d   = sel_id;
          if (sel_bypass) begin
            out_addr_d         = sel_addr;
            accept_d[grant_ch] = 1'b1;
            state_d            = RESPOND;
          end else begin
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        state_d = RESPOND;
        if (hit_multi) begin
          drop_d[gnt_q] = 1'b1;
          int_multi_d   = 1'b1;
        end else if (hit_any) begin
          accept_d[gnt_q] = 1'b1;
          out_addr_d      = lk_out_addr;
        end else if (prot_any) begin
          drop_d[gnt_q] = 1'b1;
          int_prot_d    = 1'b1;
        end else begin
          drop_d[gnt_q] = 1'b1;
          int_miss_d    = 1'b1;
          miss_addr_d   = min_q;
          miss_id_d     = {gnt_q, id_q};
        end
      end
      RESPOND: begin
        state_d = (|accept_q) ? WAIT_SENT : IDLE;
      end
      WAIT_SENT: begin
        if (req_if.req_sent[gnt_q]) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Clear wins over a coincident miss; otherwise the count sticks at all-ones.
  always_comb begin
    miss_count_d = miss_count_q;
    if (cnt_clr) begin
      miss_count_d = '0;
    end else if (int_miss_q && !(&miss_count_q)) begin
      miss_count_d = miss_count_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q      <= IDLE;
      last_q       <= CH_W'(N_CH - 1);
      gnt_q        <= '0;
      min_q        <= '0;
      max_q        <= '0;
      rw_q         <= 1'b0;
      id_q         <= '0;
      out_addr_q   <= '0;
      accept_q     <= '0;
      drop_q       <= '0;
      int_miss_q   <= 1'b0;
      int_prot_q   <= 1'b0;
      int_multi_q  <= 1'b0;
      miss_addr_q  <= '0;
      miss_id_q    <= '0;
      miss_count_q <= '0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      gnt_q        <= gnt_d;
      min_q        <= min_d;
      max_q        <= max_d;
      rw_q         <= rw_d;
      id_q         <= id_d;
      out_addr_q   <= out_addr_d;
      accept_q     <= accept_d;
      drop_q       <= drop_d;
      int_miss_q   <= int_miss_d;
      int_prot_q   <= int_prot_d;
      int_multi_q  <= int_multi_d;
      miss_addr_q  <= miss_addr_d;
      miss_id_q    <= miss_id_d;
      miss_count_q <= miss_count_d;
    end
  end

  assign req_if.accept   = accept_q;
  assign req_if.drop     = drop_q;
  assign req_if.out_addr = out_addr_q;
  assign lk_valid        = (state_q == LOOKUP);
  assign lk_addr_min     = min_q;
  assign lk_addr_max     = max_q;
  assign lk_rw           = rw_q;
  assign int_miss        = int_miss_q;
  assign int_prot        = int_prot_q;
  assign int_multi       = int_multi_q;
  assign miss_addr       = miss_addr_q;
  assign miss_id         = miss_id_q;
  assign miss_count      = miss_count_q;
endmodule

// File: tb/tb_rab_port_lookup_ctrl.sv
// Self-checking bench for rab_port_lookup_ctrl: directed scenarios plus a
// randomized run, all checked against a request-level reference model.
module tb_rab_port_lookup_ctrl;
  localparam int NCH = 4;
  localparam int CW  = 4;

  logic        clk;
  logic        rst_n;
  logic        lk_valid;
  logic [31:0] lk_addr_min;
  logic [31:0] lk_addr_max;
  logic        lk_rw;
  logic [15:0] lk_hit;
  logic [15:0] lk_prot;
  logic [31:0] lk_out_addr;
  logic        int_miss;
  logic        int_prot;
  logic        int_multi;
  logic [31:0] miss_addr;
  logic [9:0]  miss_id;
  logic        cnt_clr;
  logic [CW-1:0] miss_count;

  int errors = 0;
  int checks = 0;

  int          m_last;
  logic [CW-1:0] m_cnt;
  logic [31:0] m_miss_addr;
  logic [9:0]  m_miss_id;

  rab_port_lookup_ctrl_if #(.N_CH(NCH), .ADDR_WIDTH(32), .ID_WIDTH(8), .USER_WIDTH(6)) bus ();

  rab_port_lookup_ctrl #(
    .N_CH(NCH), .ADDR_WIDTH(32), .ID_WIDTH(8), .USER_WIDTH(6),
    .AXI_DATA_WIDTH(64), .RAB_ENTRIES(16), .CNT_WIDTH(CW)
  ) dut (
    .s_axi_aclk(clk),
    .s_axi_aresetn(rst_n),
    .req_if(bus),
    .lk_valid(lk_valid),
    .lk_addr_min(lk_addr_min),
    .lk_addr_max(lk_addr_max),
    .lk_rw(lk_rw),
    .lk_hit(lk_hit),
    .lk_prot(lk_prot),
    .lk_out_addr(lk_out_addr),
    .int_miss(int_miss),
    .int_prot(int_prot),
    .int_multi(int_multi),
    .miss_addr(miss_addr),
    .miss_id(miss_id),
    .cnt_clr(cnt_clr),
    .miss_count(miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_last      = NCH - 1;
    m_cnt       = '0;
    m_miss_addr = '0;
    m_miss_id   = '0;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_addr  = '0;
    bus.req_id    = '0;
    bus.req_len   = '0;
    bus.req_size  = '0;
    bus.req_type  = '0;
    bus.req_ctrl  = '0;
    bus.req_sent  = '0;
    lk_hit        = '0;
    lk_prot       = '0;
    lk_out_addr   = '0;
    cnt_clr       = 1'b0;
  endtask

  // One request on one channel, from IDLE back to IDLE, checked end to end.
  task automatic do_req(input int ch, input logic [31:0] addr, input logic [7:0] id,
                        input logic [7:0] len, input logic [2:0] size, input logic rw,
                        input logic [5:0] ctrl, input logic [15:0] hit, input logic [15:0] prot,
                        input logic [31:0] xaddr, input logic clr, input string tag);
    logic byp;
    int kind;
    int sh;
    longint unsigned aligned;
    longint unsigned span;
    logic [31:0] e_max;
    logic [31:0] e_out;
    logic [3:0] e_acc;
    logic [3:0] e_drop;
    logic [2:0] e_int;
    logic [3:0] g_acc;
    logic [3:0] g_drop;
    logic [2:0] g_int;
    logic [31:0] g_out;
    int lat;
    int lk_seen;
    logic done;
    byp = (ctrl == 6'h3F);
    if (byp) kind = 0;
    else if ($countones(hit) > 1) kind = 1;
    else if ($countones(hit) == 1) kind = 0;
    else if (prot != 0) kind = 2;
    else kind = 3;
    sh = (int'(size) < 3) ? int'(size) : 3;
    aligned = (longint'(addr) / (64'd1 << sh)) * (64'd1 << sh);
    span = (longint'(len) + 1) * (64'd1 << size);
    e_max = 32'(aligned + span - 1);
    e_out = byp ? addr : xaddr;
    e_acc = (kind == 0) ? 4'(1 << ch) : 4'd0;
    e_drop = (kind != 0) ? 4'(1 << ch) : 4'd0;
    e_int = {kind == 1, kind == 2, kind == 3};

    lk_hit = hit;
    lk_prot = prot;
    lk_out_addr = xaddr;
    bus.req_addr[ch*32 +: 32] = addr;
    bus.req_id[ch*8 +: 8] = id;
    bus.req_len[ch*8 +: 8] = len;
    bus.req_size[ch*3 +: 3] = size;
    bus.req_type[ch] = rw;
    bus.req_ctrl[ch*6 +: 6] = ctrl;
    bus.req_valid[ch] = 1'b1;

    lat = 0;
    lk_seen = 0;
    done = 1'b0;
    g_acc = '0;
    g_drop = '0;
    g_int = '0;
    g_out = '0;
    for (int c = 1; c <= 8 && !done; c++) begin
      @(posedge clk); #1;
      if (lk_valid) begin
        lk_seen++;
        checks++;
        if (lk_addr_min !== addr || lk_addr_max !== e_max || lk_rw !== rw) begin
          errors++;
          $display("[TB] FAIL %s lk_range: got min=%h max=%h rw=%b, expected min=%h max=%h rw=%b",
                   tag, lk_addr_min, lk_addr_max, lk_rw, addr, e_max, rw);
        end
      end
      if ((bus.accept | bus.drop) != 0) begin
        done = 1'b1;
        lat = c;
        g_acc = bus.accept;
        g_drop = bus.drop;
        g_int = {int_multi, int_prot, int_miss};
        g_out = bus.out_addr;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("[TB] FAIL %s response_timeout: got no accept/drop in 8 cycles, expected one", tag);
    end else begin
      if (lat != (byp ? 1 : 2) || lk_seen != (byp ? 0 : 1)) begin
        errors++;
        $display("[TB] FAIL %s latency: got %0d cycles lk_valid x%0d, expected %0d cycles lk_valid x%0d",
                 tag, lat, lk_seen, byp ? 1 : 2, byp ? 0 : 1);
      end
      checks++;
      if (g_acc !== e_acc || g_drop !== e_drop || g_int !== e_int) begin
        errors++;
        $display("[TB] FAIL %s decision: got acc=%b drop=%b int(mul,prot,miss)=%b, expected acc=%b drop=%b int=%b",
                 tag, g_acc, g_drop, g_int, e_acc, e_drop, e_int);
      end
      if (kind == 0) begin
        checks++;
        if (g_out !== e_out) begin
          errors++;
          $display("[TB] FAIL %s out_addr: got %h, expected %h", tag, g_out, e_out);
        end
      end
    end

    bus.req_valid[ch] = 1'b0;
    cnt_clr = clr;
    if (kind == 3) begin
      m_miss_addr = addr;
      m_miss_id = {2'(ch), id};
    end
    if (clr) m_cnt = '0;
    else if (kind == 3 && m_cnt != {CW{1'b1}}) m_cnt = m_cnt + 1'b1;
    m_last = ch;

    @(posedge clk); #1;
    cnt_clr = 1'b0;
    checks++;
    if (miss_count !== m_cnt || miss_addr !== m_miss_addr || miss_id !== m_miss_id) begin
      errors++;
      $display("[TB] FAIL %s miss_regs: got cnt=%0d addr=%h id=%h, expected cnt=%0d addr=%h id=%h",
               tag, miss_count, miss_addr, miss_id, m_cnt, m_miss_addr, m_miss_id);
    end
    checks++;
    if ((bus.accept | bus.drop) != 0 || {int_multi, int_prot, int_miss} != 0) begin
      errors++;
      $display("[TB] FAIL %s pulse_width: got acc=%b drop=%b int=%b after response, expected all 0",
               tag, bus.accept, bus.drop, {int_multi, int_prot, int_miss});
    end
    if (kind == 0) begin
      checks++;
      if (bus.out_addr !== e_out) begin
        errors++;
        $display("[TB] FAIL %s out_addr_hold: got %h, expected %h", tag, bus.out_addr, e_out);
      end
      bus.req_sent[ch] = 1'b1;
      @(posedge clk); #1;
      bus.req_sent[ch] = 1'b0;
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus.accept, bus.drop, bus.out_addr, lk_valid, lk_addr_min, lk_addr_max, lk_rw,
         int_miss, int_prot, int_multi, miss_addr, miss_id, miss_count} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got acc=%b drop=%b lk_valid=%b cnt=%0d, expected all outputs 0",
               bus.accept, bus.drop, lk_valid, miss_count);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  // All channels stay valid and every request is dropped, so grants rotate.
  task automatic test_round_robin();
    int exp_ch;
    int got_ch;
    logic done;
    lk_hit = '0;
    lk_prot = 16'h0001;
    for (int c = 0; c < NCH; c++) begin
      bus.req_addr[c*32 +: 32] = 32'h0000_0100 * c;
      bus.req_ctrl[c*6 +: 6] = 6'h00;
    end
    bus.req_valid = 4'hF;
    for (int n = 0; n < 5; n++) begin
      exp_ch = (m_last + 1) % NCH;
      done = 1'b0;
      got_ch = -1;
      for (int c = 0; c < 6 && !done; c++) begin
        @(posedge clk); #1;
        if (bus.drop != 0) begin
          done = 1'b1;
          for (int k = 0; k < NCH; k++) if (bus.drop[k]) got_ch = k;
        end
      end
      checks++;
      if (!done || bus.drop !== 4'(1 << exp_ch)) begin
        errors++;
        $display("[TB] FAIL rr_grant%0d: got drop=%b (ch %0d), expected ch %0d", n, bus.drop, got_ch, exp_ch);
      end
      m_last = exp_ch;
    end
    bus.req_valid = '0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic test_accept();
    do_req(0, 32'h1000_0004, 8'h11, 8'd3, 3'd2, 1'b1, 6'h00, 16'h0020, 16'h0000,
           32'h8000_0004, 1'b0, "accept_ch0");
  endtask

  task automatic test_bypass();
    do_req(1, 32'h2000_0000, 8'h22, 8'd0, 3'd3, 1'b0, 6'h3F, 16'h0000, 16'h0000,
           32'hDEAD_0000, 1'b0, "bypass_ch1");
  endtask

  task automatic test_miss();
    do_req(0, 32'h3000_0000, 8'h5A, 8'd1, 3'd3, 1'b0, 6'h00, 16'h0000, 16'h0000,
           32'h0, 1'b0, "miss_ch0");
  endtask

  task automatic test_lookup_cases();
    do_req(2, 32'h4000_0010, 8'h33, 8'd7, 3'd3, 1'b0, 6'h01, 16'h0011, 16'h0000,
           32'h9000_0000, 1'b0, "multi_hit");
    do_req(2, 32'h4000_0010, 8'h33, 8'd7, 3'd3, 1'b0, 6'h01, 16'h0000, 16'h0004,
           32'h9000_0000, 1'b0, "prot_only");
    do_req(3, 32'hFFFF_FFF0, 8'h44, 8'd3, 3'd3, 1'b1, 6'h00, 16'h8000, 16'h8000,
           32'h1234_5678, 1'b0, "wrap_hit_prot");
  endtask

  // Another channel's sent strobe must not release the held translation.
  task automatic test_sent_other();
    logic ok;
    lk_hit = 16'h0002;
    lk_prot = '0;
    lk_out_addr = 32'hABCD_0000;
    bus.req_addr[2*32 +: 32] = 32'h5000_0000;
    bus.req_ctrl[2*6 +: 6] = 6'h00;
    bus.req_valid[2] = 1'b1;
    ok = 1'b0;
    for (int c = 0; c < 6 && !ok; c++) begin
      @(posedge clk); #1;
      if (bus.accept[2]) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("[TB] FAIL sent_other_accept: got no accept[2], expected accept");
    end
    bus.req_valid[2] = 1'b0;
    bus.req_addr[3*32 +: 32] = 32'h6000_0040;
    bus.req_ctrl[3*6 +: 6] = 6'h00;
    bus.req_len[3*8 +: 8] = 8'd0;
    bus.req_size[3*3 +: 3] = 3'd0;
    bus.req_valid[3] = 1'b1;
    bus.req_sent[3] = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      checks++;
      if (lk_valid !== 1'b0 || bus.accept !== 4'd0 || bus.out_addr !== 32'hABCD_0000) begin
        errors++;
        $display("[TB] FAIL sent_other_hold%0d: got lk_valid=%b acc=%b out=%h, expected 0 0000 abcd0000",
                 c, lk_valid, bus.accept, bus.out_addr);
      end
    end
    bus.req_sent[3] = 1'b0;
    bus.req_sent[2] = 1'b1;
    @(posedge clk); #1;
    bus.req_sent[2] = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (lk_valid !== 1'b1 || lk_addr_min !== 32'h6000_0040 || lk_addr_max !== 32'h6000_0040) begin
      errors++;
      $display("[TB] FAIL sent_release: got lk_valid=%b min=%h max=%h, expected 1 60000040 60000040",
               lk_valid, lk_addr_min, lk_addr_max);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.accept !== 4'b1000) begin
      errors++;
      $display("[TB] FAIL sent_next_accept: got acc=%b, expected 1000", bus.accept);
    end
    bus.req_valid[3] = 1'b0;
    m_last = 3;
    @(posedge clk); #1;
    bus.req_sent[3] = 1'b1;
    @(posedge clk); #1;
    bus.req_sent[3] = 1'b0;
  endtask

  task automatic test_counter();
    for (int n = 0; n < (1 << CW) + 1; n++) begin
      do_req(n % NCH, 32'h7000_0000 + 32'(n * 8), 8'(n), 8'd0, 3'd3, 1'b0, 6'h00,
             16'h0000, 16'h0000, 32'h0, 1'b0, "count_sat");
    end
    do_req(1, 32'h7100_0000, 8'h77, 8'd0, 3'd3, 1'b0, 6'h00, 16'h0000, 16'h0000,
           32'h0, 1'b1, "clr_vs_miss");
  endtask

  task automatic test_random();
    logic [15:0] hit;
    int a;
    int b;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(3))
        0: hit = 16'h0000;
        1: hit = 16'(1 << $urandom_range(15));
        2: begin
          a = $urandom_range(15);
          b = (a + 1 + $urandom_range(14)) % 16;
          hit = 16'(1 << a) | 16'(1 << b);
        end
        default: hit = 16'($urandom);
      endcase
      do_req($urandom_range(NCH - 1), $urandom, 8'($urandom), 8'($urandom), 3'($urandom_range(7)),
             1'($urandom), ($urandom_range(3) == 0) ? 6'h3F : 6'($urandom_range(62)), hit,
             ($urandom_range(1) == 1) ? 16'($urandom) : 16'h0000, $urandom,
             ($urandom_range(7) == 0), "random");
    end
  endtask

  task automatic test_reset_mid();
    do_req(0, 32'h0800_0000, 8'h08, 8'd0, 3'd3, 1'b0, 6'h00, 16'h0000, 16'h0000,
           32'h0, 1'b0, "pre_reset_miss");
    lk_hit = 16'h0001;
    lk_out_addr = 32'hCAFE_0000;
    bus.req_addr[1*32 +: 32] = 32'h0900_0000;
    bus.req_ctrl[1*6 +: 6] = 6'h00;
    bus.req_valid[1] = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (lk_valid !== 1'b1) begin
      errors++;
      $display("[TB] FAIL reset_mid_setup: got lk_valid=%b, expected 1", lk_valid);
    end
    rst_n = 1'b0;
    bus.req_valid[1] = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({bus.accept, bus.drop, bus.out_addr, lk_valid, lk_addr_min, lk_addr_max, lk_rw,
         int_miss, int_prot, int_multi, miss_addr, miss_id, miss_count} !== '0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got acc=%b lk_valid=%b cnt=%0d addr=%h, expected all 0",
               bus.accept, lk_valid, miss_count, miss_addr);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (lk_valid !== 1'b0 || bus.accept !== 4'd0 || bus.drop !== 4'd0 || int_miss !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_mid_idle: got lk_valid=%b acc=%b drop=%b, expected 0 after reset",
               lk_valid, bus.accept, bus.drop);
    end
    do_req(0, 32'h0A00_0008, 8'h0A, 8'd1, 3'd2, 1'b0, 6'h00, 16'h0100, 16'h0000,
           32'hB000_0008, 1'b0, "post_reset_accept");
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_round_robin();
    test_accept();
    test_bypass();
    test_miss();
    test_lookup_cases();
    test_sent_other();
    test_counter();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rab_port_lookup_ctrl.md
Name: rab_port_lookup_ctrl

Overview:
Per-port lookup controller for the RAB with a generalised number of request channels (N_CH). It replaces the fixed two-channel select/priority logic and the per-port decision FSM. It round-robin arbitrates among channel requests, computes the burst address range and drives a registered request to the slice array. It then classifies the result as accept, miss, prot or multi and holds the translated address until the winning channel reports sent. One instance sits per port between the AXI address channels and the slice array.

Parameters:
N_CH, 2, number of request channels arbitrated (>=2)
ADDR_WIDTH, 32, address width
ID_WIDTH, 8, AXI ID width
USER_WIDTH, 6, AXI user/ctrl width; all-ones ctrl means bypass
AXI_DATA_WIDTH, 64, data width; alignment bits AW = log2(AXI_DATA_WIDTH/8)
RAB_ENTRIES, 16, slices per port
CNT_WIDTH, 16, miss counter width

Ports:
s_axi_aclk  in  1  clock
s_axi_aresetn  in  1  reset
req_valid  in  N_CH  per-channel address valid; held until accept/drop
req_addr  in  N_CH*ADDR_WIDTH  request address
req_id  in  N_CH*ID_WIDTH  request ID
req_len  in  N_CH*8  AXI len
req_size  in  N_CH*3  AXI size
req_type  in  N_CH  1 = write
req_ctrl  in  N_CH*USER_WIDTH  user field
req_sent  in  N_CH  downstream handshake done for accepted request
accept  out  N_CH  one-cycle accept pulse
drop  out  N_CH  one-cycle drop pulse
out_addr  out  ADDR_WIDTH  translated address, valid from accept until sent
lk_valid  out  1  lookup strobe
lk_addr_min  out  ADDR_WIDTH  registered range start
lk_addr_max  out  ADDR_WIDTH  registered range end
lk_rw  out  1  registered type
lk_hit  in  RAB_ENTRIES  combinational slice hit
lk_prot  in  RAB_ENTRIES  combinational slice hit with access-type violation
lk_out_addr  in  ADDR_WIDTH  translated address of the hitting slice
int_miss  out  1  miss pulse
int_prot  out  1  protection pulse
int_multi  out  1  multi-hit pulse
miss_addr  out  ADDR_WIDTH  address of the last miss
miss_id  out  log2(N_CH)+ID_WIDTH  {channel, id} of the last miss
cnt_clr  in  1  synchronous miss-counter clear
miss_count  out  CNT_WIDTH  saturating miss count

Behaviour:
- Reset: s_axi_aresetn, asynchronous, active-low; clock s_axi_aclk. All outputs are 0 at reset, FSM goes to IDLE and the RR pointer is set to last = N_CH-1, so channel 0 wins first.
- Arbitration: in IDLE, grant the first valid channel searching from last+1 modulo N_CH. Update last on grant.
- Range computation:
  - addr_min = req_addr.
  - Aligned address = req_addr with the low min(size, AW) bits cleared.
  - addr_max = aligned + ((len+1)<<size) - 1, modulo 2^ADDR_WIDTH (wrap permitted, no saturation).
- Bypass: a channel is in bypass when its req_ctrl is all-ones.
- FSM IDLE:
  - On grant, register channel, min, max, rw, id and bypass.
  - Bypass goes to RESPOND with out_addr = req_addr and decision accept.
  - Otherwise go to LOOKUP.
- FSM LOOKUP (1 cycle):
  - lk_valid=1; sample lk_* at the end of the cycle.
  - Decision priority:
    - popcount(lk_hit)>1 gives drop plus int_multi.
    - Exactly one hit gives accept, with out_addr = lk_out_addr.
    - Zero hits with any lk_prot gives drop plus int_prot.
    - Otherwise drop plus int_miss, and miss_addr/miss_id are loaded.
  - Go to RESPOND.
- FSM RESPOND (1 cycle):
  - accept[g] or drop[g] = 1, where g is the granted channel.
  - The interrupt pulse fires in this same cycle.
  - Drop goes to IDLE; accept goes to WAIT_SENT.
- FSM WAIT_SENT:
  - out_addr held.
  - When req_sent[g]=1, go to IDLE; a new grant is possible on the next cycle.
  - req_sent on other channels is ignored.
- Latency:
  - Lookup path: valid seen in cycle 0, lk_valid in cycle 1, accept/drop in cycle 2.
  - Bypass path: accept in cycle 1.
- Exclusivity: at most one bit of accept|drop is set per cycle; int_* pulses are mutually exclusive.
- Deasserting req_valid after grant is a protocol violation. The block completes using latched values.
- miss_count:
  - Increments on int_miss and saturates at all-ones.
  - cnt_clr has priority over a simultaneous increment (result 0).
- Reset mid-operation: the FSM aborts to IDLE immediately with no pulses emitted; miss_addr, miss_id and miss_count go to 0.

Test Plan:
- Ch0 valid with addr 0x1000_0004, len 3, size 2, a single hit on slice 5 with lk_out_addr 0x8000_0004:
  - lk_addr_min must be 0x1000_0004 and lk_addr_max 0x1000_0013.
  - accept[0] must pulse in cycle 2 with out_addr 0x8000_0004, held until req_sent[0].
- Ch1 ctrl all-ones (6'h3F) with addr 0x2000_0000: accept[1] must pulse in cycle 1, lk_valid never asserts, out_addr is 0x2000_0000.
- Ch0 addr 0x3000_0000, id 0x5A, no hit, no prot:
  - drop[0] and int_miss must pulse together.
  - miss_addr must be 0x3000_0000, miss_id {0,0x5A}, miss_count 1.
- N_CH=4 with all channels continuously valid and each request dropped: grants must go 0,1,2,3,0.
- Lookup cases on the same request:
  - lk_hit=16'h0011 must give drop plus int_multi.
  - lk_hit=0 with lk_prot=16'h0004 must give drop plus int_prot, with miss_count unchanged.
- Counter and reset:
  - miss_count preloaded to 0xFFFF plus a miss must stay at 0xFFFF.
  - cnt_clr coincident with a miss must give 0.
  - Reset asserted in LOOKUP must give all outputs 0 next cycle and a return to IDLE.
